// File: rtl/register_readout_serializer_pkg.sv
// Shared state encodings and count-width helper for the readout serializer.
package register_readout_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Beat counter must hold 0..WIDTH (parity beat included) with headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/register_readout_serializer_serial_bit_counter.sv
// Loadable up-counter with synchronous clear, async reset and terminal-count flag.
module serial_bit_counter #(
    parameter int CNT_W    = 4,
    parameter int TERMINAL = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign tc    = (cnt_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/register_readout_serializer.sv
// Parallel-to-serial readout of a result register with valid/ready on both sides.
// Optional macro PARITY_EN appends an even-parity beat after the data bits.
module register_readout_serializer
    import register_readout_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready
);

`ifdef PARITY_EN
    localparam int TOTAL = WIDTH + 1;
`else
    localparam int TOTAL = WIDTH;
`endif
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] beat_count;
    logic             last_beat;
    logic             accept;
    logic             beat;
    logic             data_bit;
    logic             ser_bit;

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                if (ser_ready && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = load_valid && load_ready;
    assign beat   = ser_valid && ser_ready;

    always_comb begin
        sreg_d = sreg_q;
        if (accept) begin
            sreg_d = load_data;
        end else if (beat) begin
            if (LSB_FIRST != 0) begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end else begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign data_bit = (LSB_FIRST != 0) ? sreg_q[0] : sreg_q[WIDTH-1];

    // Counter is cleared on the final beat so it never rests above TOTAL-1.
    serial_bit_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (TOTAL - 1)
    ) u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (beat && last_beat),
        .load     (accept),
        .load_val ({CNT_W{1'b0}}),
        .inc      (beat),
        .count    (beat_count),
        .tc       (last_beat)
    );

`ifdef PARITY_EN
    logic par_q, par_d;

    assign par_d   = accept ? ^load_data : par_q;
    assign ser_bit = (beat_count == CNT_W'(WIDTH)) ? par_q : data_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    logic unused_count;

    assign unused_count = ^beat_count;
    assign ser_bit      = data_bit;
`endif

    assign ser_out  = ser_valid && ser_bit;
    assign ser_last = ser_valid && last_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule

// File: tb/tb_register_readout_serializer.sv
// Directed bench for register_readout_serializer with a queue-based reference model.
module tb_register_readout_serializer;

    localparam int WIDTH     = 8;
    localparam int LSB_FIRST = 1;
`ifdef PARITY_EN
    localparam int TOTAL = WIDTH + 1;
`else
    localparam int TOTAL = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;

    always #5 clk = ~clk;

    register_readout_serializer #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .ser_ready  (ser_ready)
    );

    // Reference model: the bits still owed to the link, in transmit order.
    bit exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (ser_ready) void'(exp_q.pop_front());
        end else if (load_valid) begin
            for (int i = 0; i < WIDTH; i++)
                exp_q.push_back(load_data[(LSB_FIRST != 0) ? i : WIDTH - 1 - i]);
`ifdef PARITY_EN
            exp_q.push_back(^load_data);
`endif
        end
    end

    int total = 0;
    int bad   = 0;
    bit cap[$];
    bit got_last;
    int last_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: compare against the model on the falling edge, record accepted beats.
    task automatic step();
        logic [3:0] exp_v;
        @(negedge clk);
        exp_v = 4'b1000;
        if (exp_q.size() != 0) begin
            exp_v = {1'b0, 1'b1, exp_q[0], (exp_q.size() == 1)};
        end
        chk("outputs{lr,sv,so,sl}", {28'd0, load_ready, ser_valid, ser_out, ser_last}, {28'd0, exp_v});
        if (ser_valid && ser_ready && !reset) begin
            cap.push_back(ser_out);
            if (ser_last) begin
                got_last = 1'b1;
                last_idx = cap.size() - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] stream_word();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++)
            if (cap.size() > i) v[i] = cap[i];
        return v;
    endfunction

    // mode 0: ser_ready high throughout; mode 1: ser_ready pattern 1,0,0,1 repeating.
    task automatic run_word(input logic [WIDTH-1:0] w, input int mode, input bit keep_valid);
        cap.delete();
        got_last   = 1'b0;
        last_idx   = -1;
        load_data  = w;
        load_valid = 1'b1;
        ser_ready  = 1'b1;
        chk("load_ready_before_load", {31'd0, load_ready}, 32'd1);
        step();
        if (keep_valid) load_data = '0;
        else            load_valid = 1'b0;
        for (int i = 0; i < 80 && !got_last; i++) begin
            ser_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
            step();
        end
        chk("word_completed", {31'd0, got_last}, 32'd1);
        chk("beat_count", cap.size(), TOTAL);
        chk("last_position", last_idx, TOTAL - 1);
        chk("load_ready_after_last", {31'd0, load_ready}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        load_data  = '0;
        load_valid = 1'b0;
        ser_ready  = 1'b0;
        got_last   = 1'b0;
        last_idx   = -1;

        for (int i = 0; i < 3; i++) step();
        chk("reset_outputs", {28'd0, load_ready, ser_valid, ser_out, ser_last}, 32'h8);
        reset = 1'b0;
        step();

        run_word(8'hA5, 0, 1'b0);
        chk("stream_A5", stream_word(), 32'hA5);

        run_word(8'h3C, 1, 1'b0);
        chk("stream_3C_backpressure", stream_word(), 32'h3C);

        run_word(8'hFF, 0, 1'b1);
        chk("stream_FF_ignores_busy_load", stream_word(), 32'hFF);
        run_word(8'h00, 0, 1'b0);
        chk("stream_00_after_idle", stream_word(), 32'h00);

        cap.delete();
        load_data  = 8'h81;
        load_valid = 1'b1;
        ser_ready  = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("partial_beats_81", {29'd0, cap[2], cap[1], cap[0]}, 32'h1);
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {28'd0, load_ready, ser_valid, ser_out, ser_last}, 32'h8);
        step();
        step();
        reset = 1'b0;
        cap.delete();
        for (int i = 0; i < 6; i++) step();
        chk("no_beats_after_reset", cap.size(), 0);

        run_word(8'h5A, 0, 1'b0);
        chk("stream_5A_recovery", stream_word(), 32'h5A);

`ifdef PARITY_EN
        run_word(8'h07, 0, 1'b0);
        chk("parity_07", {31'd0, cap[WIDTH]}, 32'd1);
        run_word(8'h03, 0, 1'b0);
        chk("parity_03", {31'd0, cap[WIDTH]}, 32'd0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
